// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the configurable UART transmitter and the
// planned matching receiver.
//   - parity-mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - transmitter FSM state encoding
//   - frame_bits(): number of bit times in one frame
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  // Start bit + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity,
                                    input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-time counter shared by the UART transmitter and receiver.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count while high; counter is held at 0 while low
//   tick       : high in the last cycle of each bit time (count == BAUD_CNT_MAX-1)
module uart_baud_gen #(
  parameter int BAUD_CNT_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (DATA_BITS 5..9, none/odd/even
// parity, 1 or 2 stop bits) with a valid/ready input.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tx_valid   : upstream has a word on tx_pdata
//   tx_pdata   : payload, sent LSB first
//   tx_ready   : word can be accepted this cycle
//   tx_busy    : a frame is on the line
//   tx_done    : one-cycle pulse in the last cycle of the last stop bit
//   tx         : serial line, idle high
//
// Handshake: a word transfers on a rising clk edge where tx_valid & tx_ready
// are both high; tx_ready never depends on tx_valid. tx_ready is high in IDLE
// and in the final cycle of the last stop bit, so a word offered in that cycle
// starts its start bit on the very next cycle with no idle gap.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_F     = 50000000,
  parameter int UART_B    = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_pdata,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int BAUD_CNT_MAX = CLK_F / UART_B;
  localparam int FRAME_BITS   = frame_bits(DATA_BITS, PARITY, STOP_BITS);

  if (BAUD_CNT_MAX < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 ||
      PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2) || FRAME_BITS > 13) begin : g_bad_cfg
    $fatal(1, "uart_tx_cfg: illegal parameter combination");
  end

  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 last_stop;
  logic                 accept;

  uart_baud_gen #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q != S_IDLE),
    .tick (tick)
  );

  assign last_stop = (state_q == S_STOP) && tick && (stop_cnt_q == STOP_LAST);
  assign tx_ready  = (state_q == S_IDLE) || last_stop;
  assign tx_done   = last_stop;
  assign tx_busy   = (state_q != S_IDLE);
  assign tx        = tx_q;
  assign accept    = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = accept ? S_START : S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture happens in the same cycle as the move to START, from either
    // IDLE or the final stop cycle.
    if (accept) begin
      shift_d = tx_pdata;
      par_d   = (PARITY == PAR_ODD) ? ~(^tx_pdata) : (^tx_pdata);
    end

    // tx is registered: drive the value belonging to the next state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four transmitters at 8 cycles/bit (8N1, 8E1, 8O1, 5N2)
// checked cycle by cycle against a frame-waveform model, plus an LSB-first
// payload decoder on the 8N1 instance.
module tb_uart_tx_cfg;

  localparam int BAUD = 8;
  localparam int NI   = 4;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       valid [NI];
  logic [8:0] pdata [NI];
  logic       ready [NI];
  logic       busy  [NI];
  logic       done  [NI];
  logic       txl   [NI];

  int cfg_db  [NI] = '{8, 8, 8, 5};
  int cfg_par [NI] = '{0, 2, 1, 0};
  int cfg_sb  [NI] = '{1, 1, 1, 2};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB = (g == 3) ? 5 : 8;
    localparam int PR = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int SB = (g == 3) ? 2 : 1;
    uart_tx_cfg #(
      .CLK_F(800), .UART_B(100), .DATA_BITS(DB), .PARITY(PR), .STOP_BITS(SB)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_valid(valid[g]),
      .tx_pdata(pdata[g][DB-1:0]),
      .tx_ready(ready[g]),
      .tx_busy (busy[g]),
      .tx_done (done[g]),
      .tx      (txl[g])
    );
  end

  // Reference model: the whole frame as a bit list, walked one cycle at a time.
  logic [12:0] fr_bits [NI];
  int          fr_len  [NI];
  int          fr_pos  [NI];
  bit          fr_act  [NI];
  bit          acc_last[NI];

  // Scoreboard for the 8N1 payload decoder.
  logic [7:0] exp_q[$];
  logic [7:0] rx_word;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] build_frame(input int i, input logic [8:0] w,
                                              output int len);
    logic [12:0] b;
    int n;
    int ones;
    b    = '1;
    b[0] = 1'b0;
    n    = 1;
    ones = 0;
    for (int k = 0; k < cfg_db[i]; k++) begin
      b[n] = w[k];
      if (w[k]) ones++;
      n++;
    end
    if (cfg_par[i] == 2) begin
      b[n] = (ones % 2 == 1);
      n++;
    end else if (cfg_par[i] == 1) begin
      b[n] = (ones % 2 == 0);
      n++;
    end
    len = n + cfg_sb[i];
    return b;
  endfunction

  function automatic bit m_tx(input int i);
    return fr_act[i] ? fr_bits[i][fr_pos[i] / BAUD] : 1'b1;
  endfunction

  function automatic bit m_done(input int i);
    return fr_act[i] && (fr_pos[i] == fr_len[i] * BAUD - 1);
  endfunction

  function automatic bit m_ready(input int i);
    return !fr_act[i] || m_done(i);
  endfunction

  task automatic check_all();
    int b;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("tx%0d", i),    32'(txl[i]),   32'(m_tx(i)));
      check($sformatf("busy%0d", i),  32'(busy[i]),  32'(fr_act[i]));
      check($sformatf("done%0d", i),  32'(done[i]),  32'(m_done(i)));
      check($sformatf("ready%0d", i), 32'(ready[i]), 32'(m_ready(i)));
    end
    if (fr_act[0] && (fr_pos[0] % BAUD == BAUD / 2)) begin
      b = fr_pos[0] / BAUD;
      if (b >= 1 && b <= 8) rx_word[b-1] = txl[0];
    end
    if (m_done(0) && exp_q.size() > 0) begin
      check("rx0", 32'(rx_word), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic model_update();
    bit acc [NI];
    for (int i = 0; i < NI; i++) acc[i] = rst_n && valid[i] && m_ready(i);
    for (int i = 0; i < NI; i++) begin
      if (fr_act[i]) begin
        fr_pos[i]++;
        if (fr_pos[i] == fr_len[i] * BAUD) fr_act[i] = 1'b0;
      end
      if (!rst_n) fr_act[i] = 1'b0;
      acc_last[i] = acc[i];
      if (acc[i]) begin
        fr_bits[i] = build_frame(i, pdata[i], fr_len[i]);
        fr_act[i]  = 1'b1;
        fr_pos[i]  = 0;
        if (i == 0) exp_q.push_back(pdata[0][7:0]);
      end
    end
    if (!rst_n) exp_q.delete();
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic all_valid(input bit v);
    for (int i = 0; i < NI; i++) valid[i] = v;
  endtask

  int b2b_cnt;

  initial begin
    for (int i = 0; i < NI; i++) begin
      valid[i]    = 1'b0;
      pdata[i]    = '0;
      fr_act[i]   = 1'b0;
      fr_pos[i]   = 0;
      fr_len[i]   = 0;
      fr_bits[i]  = '1;
      acc_last[i] = 1'b0;
    end
    rx_word = '0;

    @(negedge clk);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Directed words: A5 (8N1), 07 (8E1), 07 (8O1), 13 (5N2).
    pdata[0] = 9'h0A5;
    pdata[1] = 9'h007;
    pdata[2] = 9'h007;
    pdata[3] = 9'h013;
    all_valid(1'b1);
    step();
    all_valid(1'b0);
    repeat (15) step();
    // Words offered mid-frame must be ignored.
    for (int i = 0; i < NI; i++) pdata[i] = 9'($urandom_range(0, 511));
    all_valid(1'b1);
    step();
    all_valid(1'b0);
    repeat (90) step();

    // Back-to-back 55 then AA on the 8N1 instance, valid held high.
    b2b_cnt  = 0;
    valid[0] = 1'b1;
    pdata[0] = 9'h055;
    for (int c = 0; c < 200; c++) begin
      step();
      if (acc_last[0]) begin
        b2b_cnt++;
        if (b2b_cnt == 1) pdata[0] = 9'h0AA;
        else valid[0] = 1'b0;
      end
      if (b2b_cnt == 2 && !fr_act[0]) break;
    end
    check("b2b_accepts", 32'(b2b_cnt), 32'd2);
    repeat (2) step();

    // Reset 30 cycles into a frame: outputs go idle without a clock edge.
    for (int i = 0; i < NI; i++) pdata[i] = 9'($urandom_range(0, 511));
    all_valid(1'b1);
    step();
    all_valid(1'b0);
    repeat (29) step();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_tx%0d", i),    32'(txl[i]),   32'd1);
      check($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
      check($sformatf("rst_busy%0d", i),  32'(busy[i]),  32'd0);
      check($sformatf("rst_done%0d", i),  32'(done[i]),  32'd0);
      fr_act[i] = 1'b0;
    end
    exp_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NI; i++) pdata[i] = 9'($urandom_range(0, 511));
    all_valid(1'b1);
    step();
    all_valid(1'b0);
    repeat (100) step();

    // Random traffic: frequent valid with fresh data every cycle.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NI; i++) begin
        valid[i] = ($urandom_range(0, 3) != 0);
        pdata[i] = 9'($urandom_range(0, 511));
      end
      step();
    end
    all_valid(1'b0);
    repeat (100) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter that replaces the fixed 8N1 sender. It supports configurable data width, parity mode and stop-bit count, and uses a valid/ready input handshake so back-to-back bytes go out with no idle gap. It sits between the SM4 result serialiser and the board TX pin. It emits a one-cycle tx_done per frame and holds tx_busy for the whole frame.

Parameters:
CLK_F, 50000000, main clock frequency in Hz
UART_B, 9600, baud rate in bit/s
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  main clock
rst_n  input  1  asynchronous active-low reset
tx_valid  input  1  upstream asserts while tx_pdata holds a byte to send
tx_pdata  input  DATA_BITS  parallel payload, sent LSB first
tx_ready  output  1  block can accept a word this cycle
tx_busy  output  1  a frame is in progress
tx_done  output  1  one-cycle pulse at the end of the last stop bit
tx  output  1  serial line, idle high

Behaviour:
- Reset (rst_n low, asynchronous): tx=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, all counters 0. A reset asserted mid-frame aborts the frame immediately, tx returns to 1, and no tx_done is produced.
- BAUD_CNT_MAX = CLK_F/UART_B. Baud counter width = $clog2(BAUD_CNT_MAX). Every bit lasts exactly BAUD_CNT_MAX cycles.
- Elaboration check: fatal if BAUD_CNT_MAX<2, DATA_BITS outside 5..9, PARITY>2, or STOP_BITS not in {1,2}.
- Handshake: a word is accepted on a rising clk edge where tx_valid & tx_ready. tx_pdata is captured into a shift register at that edge. The parity bit is computed at capture: even = XOR of the data bits, odd = its inverse.
- tx_ready = 1 in IDLE. It also goes to 1 in the final cycle of the last stop bit, the same cycle as tx_done. It is 0 otherwise.
- Back-to-back: if a word is accepted in the tx_done cycle, the next start bit begins on the following cycle with no idle bit.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE, or STOP -> START on back-to-back.
  - PARITY is skipped when PARITY=0.
  - STOP lasts STOP_BITS bit times.
  - Each transition occurs when the baud counter reaches BAUD_CNT_MAX-1.
- Timing: accept at edge N; tx=0 from cycle N+1 (registered output). Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_CNT_MAX cycles.
- Bit order and values: DATA shifts out LSB first, a bit counter counts 0..DATA_BITS-1. PARITY drives the stored parity bit. STOP drives 1.
- tx_busy = 1 from cycle N+1 through the final stop cycle inclusive. It stays 1 continuously across back-to-back frames.
- tx_done = 1 for exactly one cycle: the last cycle of the last stop bit.
- tx_valid without tx_ready: no effect; the data is ignored until ready.
- tx_pdata changing after acceptance: no effect on the frame in flight.

Decomposition:
- Package uart_pkg:
  - parity-mode localparams PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - FSM state encoding
  - a function computing the frame length in bits
- Sub-module uart_baud_gen(clk, rst_n, en, tick):
  - counts while en and pulses tick at BAUD_CNT_MAX-1
  - clears when en=0
  - this module is reused by the planned matching receiver.

Test Plan:
- CLK_F=800, UART_B=100 (8 cycles/bit), 8N1: send 8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; tx_done one pulse 80 cycles after the first start cycle; tx_busy high for exactly 80 cycles.
- Same timing, DATA_BITS=8, PARITY=2: send 8'h07 -> parity bit 1, frame 88 cycles. With PARITY=1, the same word gives parity bit 0.
- DATA_BITS=5, STOP_BITS=2, PARITY=0: send 5'h13 -> bits 0,1,1,0,0,1,1,1; tx_done at cycle 64.
- Hold tx_valid high with words 8'h55 then 8'hAA -> second start bit immediately follows the first frame's stop bit; tx_ready high only in the two tx_done cycles; tx_busy never drops between frames.
- Assert rst_n low at cycle 30 of a frame -> tx=1 and tx_ready=1 immediately with no clock edge; no tx_done; the next accepted word produces a clean full frame.
- tx_valid pulsed while tx_busy -> word ignored; only the original frame appears on tx.
